// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash access arbiter.
// No logic of its own; the helper below is purely combinational.
// No flow control here; consumers apply it.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_N64 = 1'b1;

    localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

    // Two-way round-robin pick: a sole requester wins, a tie goes to the side not served last.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_grant);
        logic [1:0] pick;
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = (last_grant == REQ_N64) ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin selector; grant bit 0 is the CPU, bit 1 is N64.
// Grant is combinational from req; last-grant updates on the cycle after advance.
// Losing requester simply sees no grant until its turn comes.
module rr_arbiter_2 (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    import flash_arb_pkg::*;

    logic last_grant;

    assign grant = rr_pick(req, last_grant);

    // Remember who was served so the next tie goes the other way; N64 after reset so the CPU wins first.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            last_grant <= REQ_N64;
        end else if (advance && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/flash_access_arbiter.sv
// Shares the single-ported flash read port between CPU and N64 with one read in flight.
// Zero-wait flash with 1-cycle ack: accept T, request T+1, owner ack T+3.
// Requester busy stays high until granted in IDLE; flash busy holds the request in ISSUE.
module flash_access_arbiter #(
    parameter int ADDRESS_WIDTH  = 19,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_cpu_request,
    output logic                     o_cpu_busy,
    output logic                     o_cpu_ack,
    input  logic [ADDRESS_WIDTH-1:0] i_cpu_address,
    output logic [31:0]              o_cpu_data,
    input  logic                     i_n64_request,
    output logic                     o_n64_busy,
    output logic                     o_n64_ack,
    input  logic [ADDRESS_WIDTH-1:0] i_n64_address,
    output logic [31:0]              o_n64_data,
    output logic                     o_flash_request,
    input  logic                     i_flash_busy,
    input  logic                     i_flash_ack,
    output logic [ADDRESS_WIDTH-1:0] o_flash_address,
    input  logic [31:0]              i_flash_data,
    output logic                     o_timeout
);
    import flash_arb_pkg::*;

    localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT_CYCLES);

    arb_state_t               state;
    logic                     owner;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [CW-1:0]            wait_cnt;
    logic [1:0]               grant;
    logic                     accept;
    logic                     done;
    logic [31:0]              done_data;

    rr_arbiter_2 u_rr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .req     ({i_n64_request, i_cpu_request}),
        .advance (accept),
        .grant   (grant)
    );

    // Grants only mean anything while idle; outside IDLE both requesters are held off.
    assign accept     = (state == IDLE) && (grant != 2'b00);
    assign o_cpu_busy = !((state == IDLE) && grant[0]);
    assign o_n64_busy = !((state == IDLE) && grant[1]);

    assign o_flash_address = addr_q;

    // A real ack wins over the watchdog when both land in the same cycle.
    assign done      = i_flash_ack || (wait_cnt == CNT_MAX);
    assign done_data = i_flash_ack ? i_flash_data : TIMEOUT_DATA;

    // Transaction FSM with registered strobes, owner latch, watchdog and per-owner data return.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= IDLE;
            owner           <= REQ_CPU;
            addr_q          <= '0;
            wait_cnt        <= '0;
            o_flash_request <= 1'b0;
            o_cpu_ack       <= 1'b0;
            o_n64_ack       <= 1'b0;
            o_timeout       <= 1'b0;
            o_cpu_data      <= '0;
            o_n64_data      <= '0;
        end else begin
            o_cpu_ack <= 1'b0;
            o_n64_ack <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    // Flash acks arriving here are leftovers from a dropped transaction.
                    if (accept) begin
                        owner           <= grant[1];
                        addr_q          <= grant[1] ? i_n64_address : i_cpu_address;
                        o_flash_request <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!i_flash_busy) begin
                        o_flash_request <= 1'b0;
                        wait_cnt        <= '0;
                        state           <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                    if (done) begin
                        if (owner == REQ_N64) begin
                            o_n64_data <= done_data;
                            o_n64_ack  <= 1'b1;
                        end else begin
                            o_cpu_data <= done_data;
                            o_cpu_ack  <= 1'b1;
                        end
                        o_timeout <= !i_flash_ack;
                        state     <= IDLE;
                    end
                end
                default: begin
                    o_flash_request <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_access_arbiter.sv
// Self-checking bench for flash_access_arbiter with a behavioural flash responder.
// Expected timing/data come from the transaction-level rules, not the RTL structure.
// Flash stall and ack delay are configurable per transaction.
module tb_flash_access_arbiter;

    localparam int AW = 19;
    localparam int TO = 8;

    logic          i_clk;
    logic          i_reset;
    logic          cpu_req, n64_req;
    logic          o_cpu_busy, o_n64_busy, o_cpu_ack, o_n64_ack;
    logic [AW-1:0] cpu_addr, n64_addr;
    logic [31:0]   o_cpu_data, o_n64_data;
    logic          o_flash_request, i_flash_busy, i_flash_ack, o_timeout;
    logic [AW-1:0] o_flash_address;
    logic [31:0]   i_flash_data;

    int checks = 0;
    int fails  = 0;

    // Flash responder configuration
    int          flash_stall = 0;
    int          flash_delay = 1;
    bit          fixed_on    = 0;
    logic [31:0] fixed_data  = '0;
    logic [31:0] salt;

    // Reference model state
    int          model_last = 1;
    logic [31:0] exp_data [2];

    flash_access_arbiter #(.ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_cpu_request   (cpu_req),
        .o_cpu_busy      (o_cpu_busy),
        .o_cpu_ack       (o_cpu_ack),
        .i_cpu_address   (cpu_addr),
        .o_cpu_data      (o_cpu_data),
        .i_n64_request   (n64_req),
        .o_n64_busy      (o_n64_busy),
        .o_n64_ack       (o_n64_ack),
        .i_n64_address   (n64_addr),
        .o_n64_data      (o_n64_data),
        .o_flash_request (o_flash_request),
        .i_flash_busy    (i_flash_busy),
        .i_flash_ack     (i_flash_ack),
        .o_flash_address (o_flash_address),
        .i_flash_data    (i_flash_data),
        .o_timeout       (o_timeout)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [31:0] pat(input logic [AW-1:0] a);
        return ({13'd0, a} * 32'h9E37_79B1) ^ salt;
    endfunction

    // Flash model: optional busy stall on each new request, then an ack flash_delay cycles later (0 = never).
    initial begin
        int          ack_cd;
        int          busy_left;
        bit          in_req;
        logic [31:0] fl_data;
        ack_cd = 0; busy_left = 0; in_req = 0; fl_data = '0;
        i_flash_busy = 1'b0; i_flash_ack = 1'b0; i_flash_data = '0;
        forever begin
            @(posedge i_clk); #1;
            i_flash_ack = 1'b0;
            if (ack_cd > 0) begin
                ack_cd--;
                if (ack_cd == 0) begin
                    i_flash_ack  = 1'b1;
                    i_flash_data = fl_data;
                end
            end
            if (o_flash_request) begin
                if (!in_req) begin
                    in_req    = 1;
                    busy_left = flash_stall;
                end
                if (busy_left > 0) begin
                    i_flash_busy = 1'b1;
                    busy_left--;
                end else begin
                    i_flash_busy = 1'b0;
                    in_req       = 0;
                    ack_cd       = flash_delay;
                    fl_data      = fixed_on ? fixed_data : pat(o_flash_address);
                end
            end else begin
                in_req       = 0;
                i_flash_busy = 1'($urandom_range(0, 1));
            end
        end
    end

    // One read by a single requester; checks request window, ack timing, data routing and timeout flag.
    task automatic run_read(input int who, input logic [AW-1:0] addr, input int stall,
                            input int delay, input bit fixed, input logic [31:0] fdat);
        int          n;
        int          lat;
        int          total;
        int          other;
        bit          got;
        bit          to_exp;
        logic [31:0] dexp;
        logic        own_ack, oth_ack;
        logic [31:0] own_dat, oth_dat;
        other = 1 - who;
        flash_stall = stall; flash_delay = delay; fixed_on = fixed; fixed_data = fdat;
        if (who == 0) begin cpu_req = 1'b1; cpu_addr = addr; end
        else begin n64_req = 1'b1; n64_addr = addr; end
        got = 0;
        for (n = 0; n < 20 && !got; n++) begin
            @(negedge i_clk);
            if ((who == 0) ? !o_cpu_busy : !o_n64_busy) got = 1;
            else begin @(posedge i_clk); #1; end
        end
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL accept: requester %0d never accepted (busy stuck 1, required 0)", who);
            cpu_req = 1'b0; n64_req = 1'b0;
            return;
        end
        model_last = who;
        to_exp = !(delay >= 1 && delay <= TO + 1);
        lat    = to_exp ? TO + 1 : delay;
        total  = 2 + stall + lat;
        dexp   = to_exp ? 32'hFFFF_FFFF : (fixed ? fdat : pat(addr));
        @(posedge i_clk); #1;
        cpu_req = 1'b0; n64_req = 1'b0;
        for (n = 1; n <= total + 1; n++) begin
            @(negedge i_clk);
            own_ack = (who == 0) ? o_cpu_ack : o_n64_ack;
            oth_ack = (who == 0) ? o_n64_ack : o_cpu_ack;
            own_dat = (who == 0) ? o_cpu_data : o_n64_data;
            oth_dat = (who == 0) ? o_n64_data : o_cpu_data;
            checks++;
            if (o_flash_request !== (n <= 1 + stall)) begin
                fails++;
                $display("FAIL flash_req: cycle %0d got %b required %b", n, o_flash_request, (n <= 1 + stall));
            end
            if (n <= 1 + stall) begin
                checks++;
                if (o_flash_address !== addr) begin
                    fails++;
                    $display("FAIL flash_addr: cycle %0d got %h required %h", n, o_flash_address, addr);
                end
            end
            checks++;
            if (own_ack !== (n == total)) begin
                fails++;
                $display("FAIL owner_ack: who %0d cycle %0d got %b required %b", who, n, own_ack, (n == total));
            end
            checks++;
            if (oth_ack !== 1'b0) begin
                fails++;
                $display("FAIL other_ack: who %0d cycle %0d got %b required 0", who, n, oth_ack);
            end
            checks++;
            if (o_timeout !== (n == total && to_exp)) begin
                fails++;
                $display("FAIL timeout: cycle %0d got %b required %b", n, o_timeout, (n == total && to_exp));
            end
            if (n == total) begin
                checks++;
                if (own_dat !== dexp) begin
                    fails++;
                    $display("FAIL owner_data: who %0d got %h required %h", who, own_dat, dexp);
                end
                checks++;
                if (oth_dat !== exp_data[other]) begin
                    fails++;
                    $display("FAIL other_data: who %0d got %h required %h", other, oth_dat, exp_data[other]);
                end
            end
            @(posedge i_clk); #1;
        end
        exp_data[who] = dexp;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; cpu_req = 1'b0; n64_req = 1'b0; cpu_addr = '0; n64_addr = '0;
        exp_data[0] = '0; exp_data[1] = '0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
        model_last = 1;
        @(negedge i_clk);
        checks++;
        if ({o_cpu_ack, o_n64_ack, o_timeout, o_flash_request} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_strobes: got %b required 0000", {o_cpu_ack, o_n64_ack, o_timeout, o_flash_request});
        end
        checks++;
        if (o_cpu_data !== 32'd0 || o_n64_data !== 32'd0 || o_flash_address !== '0) begin
            fails++;
            $display("FAIL reset_regs: cpu %h n64 %h addr %h required all 0", o_cpu_data, o_n64_data, o_flash_address);
        end
        checks++;
        if ({o_cpu_busy, o_n64_busy} !== 2'b11) begin
            fails++;
            $display("FAIL reset_busy: got %b required 11", {o_cpu_busy, o_n64_busy});
        end
        // Tie straight after reset must favour the CPU; requests withdrawn before the edge.
        cpu_req = 1'b1; n64_req = 1'b1;
        #1;
        checks++;
        if ({o_cpu_busy, o_n64_busy} !== 2'b01) begin
            fails++;
            $display("FAIL first_tie: busy cpu/n64 got %b required 01", {o_cpu_busy, o_n64_busy});
        end
        cpu_req = 1'b0;
        #1;
        checks++;
        if ({o_cpu_busy, o_n64_busy} !== 2'b10) begin
            fails++;
            $display("FAIL sole_n64: busy cpu/n64 got %b required 10", {o_cpu_busy, o_n64_busy});
        end
        n64_req = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_round_robin();
        int          accepts;
        int          cnt [2];
        int          w;
        int          exp_w;
        bit          pend;
        int          pend_who;
        int          pend_cyc;
        logic [31:0] pend_dat;
        accepts = 0; cnt[0] = 0; cnt[1] = 0; pend = 0; pend_who = 0; pend_cyc = 0; pend_dat = '0;
        flash_stall = 0; flash_delay = 1; fixed_on = 0;
        cpu_addr = 19'h00100; n64_addr = 19'h00200;
        cpu_req = 1'b1; n64_req = 1'b1;
        for (int cyc = 0; cyc < 200 && (accepts < 16 || pend); cyc++) begin
            @(negedge i_clk);
            checks++;
            if (o_cpu_ack !== (pend && cyc == pend_cyc && pend_who == 0) ||
                o_n64_ack !== (pend && cyc == pend_cyc && pend_who == 1)) begin
                fails++;
                $display("FAIL rr_ack: cycle %0d got cpu %b n64 %b required owner %0d at %0d",
                         cyc, o_cpu_ack, o_n64_ack, pend_who, pend_cyc);
            end
            if (pend && cyc == pend_cyc) begin
                checks++;
                if (((pend_who == 0) ? o_cpu_data : o_n64_data) !== pend_dat) begin
                    fails++;
                    $display("FAIL rr_data: owner %0d got %h required %h", pend_who,
                             (pend_who == 0) ? o_cpu_data : o_n64_data, pend_dat);
                end
                exp_data[pend_who] = pend_dat;
                pend = 0;
            end
            if (accepts < 16 && (!o_cpu_busy || !o_n64_busy)) begin
                w     = !o_cpu_busy ? 0 : 1;
                exp_w = 1 - model_last;
                checks++;
                if (w != exp_w || (!o_cpu_busy && !o_n64_busy)) begin
                    fails++;
                    $display("FAIL rr_grant: accept %0d got busy cpu/n64 %b%b required winner %0d",
                             accepts, o_cpu_busy, o_n64_busy, exp_w);
                end
                model_last = exp_w;
                pend = 1; pend_who = w; pend_cyc = cyc + 3;
                pend_dat = pat((w == 0) ? 19'h00100 : 19'h00200);
                accepts++;
                cnt[w]++;
            end
            @(posedge i_clk); #1;
            if (accepts >= 16) begin cpu_req = 1'b0; n64_req = 1'b0; end
        end
        cpu_req = 1'b0; n64_req = 1'b0;
        checks++;
        if (accepts != 16 || cnt[0] != 8 || cnt[1] != 8 || pend) begin
            fails++;
            $display("FAIL rr_fairness: accepts %0d cpu %0d n64 %0d pending %0d required 16/8/8/0",
                     accepts, cnt[0], cnt[1], pend);
        end
    endtask

    task automatic test_single_read();
        run_read(0, 19'h00010, 0, 1, 1, 32'hDEAD_BEEF);
    endtask

    task automatic test_flash_busy();
        run_read(1, 19'h2A5A5, 3, 1, 0, 32'd0);
    endtask

    task automatic test_timeout();
        run_read(0, 19'h01234, 0, 0, 0, 32'd0);
        run_read(0, 19'h01235, 0, 2, 0, 32'd0);
        run_read(1, 19'h7FFFF, 1, 0, 0, 32'd0);
    endtask

    task automatic test_ack_timeout_same_cycle();
        run_read(1, 19'h03333, 0, TO + 1, 0, 32'd0);
        run_read(0, 19'h04444, 2, TO + 1, 0, 32'd0);
    endtask

    task automatic test_reset_mid();
        bit got;
        flash_stall = 0; flash_delay = 4; fixed_on = 0;
        cpu_req = 1'b1; cpu_addr = 19'h00123;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge i_clk);
            if (!o_cpu_busy) got = 1;
            else begin @(posedge i_clk); #1; end
        end
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL rst_mid_accept: cpu busy stuck 1, required 0");
        end
        @(posedge i_clk); #1;
        cpu_req = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        exp_data[0] = '0; exp_data[1] = '0;
        model_last = 1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge i_clk);
            checks++;
            if ({o_cpu_ack, o_n64_ack, o_timeout, o_flash_request} !== 4'b0000 ||
                o_cpu_data !== 32'd0 || o_n64_data !== 32'd0) begin
                fails++;
                $display("FAIL rst_mid_quiet: cycle %0d strobes %b cpu %h n64 %h required all 0",
                         n, {o_cpu_ack, o_n64_ack, o_timeout, o_flash_request}, o_cpu_data, o_n64_data);
            end
            @(posedge i_clk); #1;
        end
        run_read(0, 19'h00456, 0, 1, 0, 32'd0);
    endtask

    task automatic test_random();
        int          who;
        int          stall;
        int          delay;
        logic [AW-1:0] addr;
        for (int i = 0; i < 12; i++) begin
            who   = $urandom_range(0, 1);
            addr  = AW'($urandom);
            stall = $urandom_range(0, 3);
            delay = $urandom_range(0, TO + 1);
            run_read(who, addr, stall, delay, 0, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        salt = $urandom;
        test_reset();
        test_round_robin();
        test_single_read();
        test_flash_busy();
        test_timeout();
        test_ack_timeout_same_cycle();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
